// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared widths, default depth and tag-match helper for the issue queue
package issue_pkg;

    localparam int TAG_W         = 6;
    localparam int PAYLOAD_W     = 32;
    localparam int DEPTH_DEFAULT = 8;

    // A broadcast matches a source tag only while the CDB is valid.
    function automatic logic tag_hit(
        input logic             cdb_valid,
        input logic [TAG_W-1:0] cdb_tag,
        input logic [TAG_W-1:0] src_tag
    );
        return cdb_valid && (cdb_tag == src_tag);
    endfunction

endpackage

// File: rtl/issue_queue_scheduler_if.sv
// rtl/issue_queue_scheduler_if.sv - dispatch, CDB, issue and status bundle of the issue queue
//
// slave  : the queue (receives dispatch/CDB/issue_ready/flush, drives
//          disp_ready, issue outputs and occupancy)
// master : the surrounding core (rename/dispatch, CDB, functional unit)
interface issue_queue_scheduler_if
    import issue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                 flush;

    logic                 disp_valid;
    logic                 disp_ready;
    logic [TAG_W-1:0]     disp_src1_tag;
    logic                 disp_src1_rdy;
    logic [TAG_W-1:0]     disp_src2_tag;
    logic                 disp_src2_rdy;
    logic [TAG_W-1:0]     disp_dst_tag;
    logic [PAYLOAD_W-1:0] disp_payload;

    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;

    logic                 issue_valid;
    logic                 issue_ready;
    logic [TAG_W-1:0]     issue_dst_tag;
    logic [PAYLOAD_W-1:0] issue_payload;

    logic [OCC_W-1:0]     occupancy;

    modport slave (
        input  flush,
        input  disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
               disp_src2_rdy, disp_dst_tag, disp_payload,
        output disp_ready,
        input  cdb_valid, cdb_tag,
        output issue_valid, issue_dst_tag, issue_payload,
        input  issue_ready,
        output occupancy
    );

    modport master (
        output flush,
        output disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
               disp_src2_rdy, disp_dst_tag, disp_payload,
        input  disp_ready,
        output cdb_valid, cdb_tag,
        input  issue_valid, issue_dst_tag, issue_payload,
        output issue_ready,
        input  occupancy
    );

endinterface

// File: rtl/iq_entry.sv
// rtl/iq_entry.sv - one issue-queue entry with CDB wakeup and dispatch-time bypass
//
// Ports: clk, rst (sync, active-high), clear (flush), wr_en + wr_* (allocate),
//        cdb_valid/cdb_tag (wakeup), free (issued), valid/eligible/dst_tag/payload.
module iq_entry
    import issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [TAG_W-1:0]     wr_s1_tag,
    input  logic                 wr_s1_rdy,
    input  logic [TAG_W-1:0]     wr_s2_tag,
    input  logic                 wr_s2_rdy,
    input  logic [TAG_W-1:0]     wr_dst_tag,
    input  logic [PAYLOAD_W-1:0] wr_payload,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic                 free,
    output logic                 valid,
    output logic                 eligible,
    output logic [TAG_W-1:0]     dst_tag,
    output logic [PAYLOAD_W-1:0] payload
);

    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;
    logic             s1_rdy;
    logic             s2_rdy;

    logic wake1;
    logic wake2;
    logic byp1;
    logic byp2;

    assign wake1 = tag_hit(cdb_valid, cdb_tag, s1_tag);
    assign wake2 = tag_hit(cdb_valid, cdb_tag, s2_tag);
    // A result broadcast in the dispatch cycle would otherwise be missed.
    assign byp1  = tag_hit(cdb_valid, cdb_tag, wr_s1_tag);
    assign byp2  = tag_hit(cdb_valid, cdb_tag, wr_s2_tag);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid  <= 1'b0;
            s1_rdy <= 1'b0;
            s2_rdy <= 1'b0;
        end else if (wr_en) begin
            valid  <= 1'b1;
            s1_rdy <= wr_s1_rdy || byp1;
            s2_rdy <= wr_s2_rdy || byp2;
        end else if (free) begin
            valid  <= 1'b0;
            s1_rdy <= 1'b0;
            s2_rdy <= 1'b0;
        end else if (valid) begin
            if (wake1) s1_rdy <= 1'b1;
            if (wake2) s2_rdy <= 1'b1;
        end
    end

    // Tags and payload are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            s1_tag  <= wr_s1_tag;
            s2_tag  <= wr_s2_tag;
            dst_tag <= wr_dst_tag;
            payload <= wr_payload;
        end
    end

    assign eligible = valid && s1_rdy && s2_rdy;

endmodule

// File: rtl/issue_queue_scheduler.sv
// rtl/issue_queue_scheduler.sv - tag-matching issue queue with fixed-priority select
//
// Ports: clk, rst (sync, active-high), iq (slave modport: flush, dispatch
//        handshake, CDB broadcast, issue handshake, occupancy).
module issue_queue_scheduler
    import issue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
)(
    input  logic                    clk,
    input  logic                    rst,
    issue_queue_scheduler_if.slave  iq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     ent_valid;
    logic [DEPTH-1:0]     ent_elig;
    logic [DEPTH-1:0]     wr_sel;
    logic [DEPTH-1:0]     free_sel;
    logic [TAG_W-1:0]     ent_dst     [DEPTH];
    logic [PAYLOAD_W-1:0] ent_payload [DEPTH];

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             disp_fire;
    logic             issue_fire;
    logic [OCC_W-1:0] occ_q;

    // Lowest-index free slot; iterating downward leaves the lowest hit last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index eligible entry wins issue.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_elig[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign iq.disp_ready = (occ_q != OCC_W'(DEPTH));
    // A dispatch offered during flush is dropped; free_found is implied by
    // disp_ready but kept so a slot is never written without one being free.
    assign disp_fire     = iq.disp_valid && iq.disp_ready && free_found && !iq.flush;
    assign issue_fire    = sel_found && iq.issue_ready;

    assign iq.issue_valid   = sel_found;
    assign iq.issue_dst_tag = sel_found ? ent_dst[sel_idx]     : '0;
    assign iq.issue_payload = sel_found ? ent_payload[sel_idx] : '0;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_entry
            // The freed entry is valid and the written one is not, so the two
            // selects never hit the same slot in one cycle.
            assign wr_sel[g]   = disp_fire  && (free_idx == IDX_W'(g));
            assign free_sel[g] = issue_fire && (sel_idx  == IDX_W'(g));

            iq_entry u_entry (
                .clk        (clk),
                .rst        (rst),
                .clear      (iq.flush),
                .wr_en      (wr_sel[g]),
                .wr_s1_tag  (iq.disp_src1_tag),
                .wr_s1_rdy  (iq.disp_src1_rdy),
                .wr_s2_tag  (iq.disp_src2_tag),
                .wr_s2_rdy  (iq.disp_src2_rdy),
                .wr_dst_tag (iq.disp_dst_tag),
                .wr_payload (iq.disp_payload),
                .cdb_valid  (iq.cdb_valid),
                .cdb_tag    (iq.cdb_tag),
                .free       (free_sel[g]),
                .valid      (ent_valid[g]),
                .eligible   (ent_elig[g]),
                .dst_tag    (ent_dst[g]),
                .payload    (ent_payload[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || iq.flush) begin
            occ_q <= '0;
        end else begin
            case ({disp_fire, issue_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign iq.occupancy = occ_q;

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// tb/tb_issue_queue_scheduler.sv - directed self-checking bench for issue_queue_scheduler
module tb_issue_queue_scheduler;
    import issue_pkg::*;

    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    issue_queue_scheduler_if #(.DEPTH(DEPTH)) iq ();

    issue_queue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .iq  (iq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        iq.flush         = 1'b0;
        iq.disp_valid    = 1'b0;
        iq.disp_src1_tag = '0;
        iq.disp_src1_rdy = 1'b0;
        iq.disp_src2_tag = '0;
        iq.disp_src2_rdy = 1'b0;
        iq.disp_dst_tag  = '0;
        iq.disp_payload  = '0;
        iq.cdb_valid     = 1'b0;
        iq.cdb_tag       = '0;
    endtask

    task automatic disp(input int s1, input bit r1, input int s2, input bit r2,
                        input int dst, input logic [31:0] pl);
        iq.disp_valid    = 1'b1;
        iq.disp_src1_tag = TAG_W'(s1);
        iq.disp_src1_rdy = r1;
        iq.disp_src2_tag = TAG_W'(s2);
        iq.disp_src2_rdy = r2;
        iq.disp_dst_tag  = TAG_W'(dst);
        iq.disp_payload  = pl;
    endtask

    task automatic cdb(input int tag);
        iq.cdb_valid = 1'b1;
        iq.cdb_tag   = TAG_W'(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        iq.issue_ready = 1'b0;

        // Reset held two cycles with a dispatch pending.
        rst = 1'b1;
        disp(1, 1, 2, 1, 7, 32'hDEAD);
        tick();
        tick();
        chk("rst_issue_valid", 32'(iq.issue_valid), 0);
        chk("rst_occupancy", 32'(iq.occupancy), 0);
        chk("rst_disp_ready", 32'(iq.disp_ready), 1);
        chk("rst_issue_dst", 32'(iq.issue_dst_tag), 0);
        chk("rst_issue_payload", iq.issue_payload, 0);
        rst = 1'b0;
        idle();
        tick();
        chk("rst_nothing_written", 32'(iq.occupancy), 0);
        chk("rst_no_issue", 32'(iq.issue_valid), 0);

        // Ready dispatch issues one cycle later.
        disp(5, 1, 9, 1, 12, 32'hA5A5);
        iq.issue_ready = 1'b1;
        tick();
        idle();
        chk("rdy_issue_valid", 32'(iq.issue_valid), 1);
        chk("rdy_issue_dst", 32'(iq.issue_dst_tag), 12);
        chk("rdy_issue_payload", iq.issue_payload, 32'hA5A5);
        chk("rdy_occupancy", 32'(iq.occupancy), 1);
        tick();
        chk("rdy_drained", 32'(iq.occupancy), 0);
        chk("rdy_empty_no_issue", 32'(iq.issue_valid), 0);

        // CDB wakeup two cycles after dispatch.
        disp(3, 0, 4, 1, 20, 32'h1111);
        tick();
        idle();
        chk("wk_waiting0", 32'(iq.issue_valid), 0);
        chk("wk_occ", 32'(iq.occupancy), 1);
        tick();
        chk("wk_waiting1", 32'(iq.issue_valid), 0);
        cdb(3);
        tick();
        idle();
        chk("wk_issue_valid", 32'(iq.issue_valid), 1);
        chk("wk_issue_dst", 32'(iq.issue_dst_tag), 20);
        tick();
        chk("wk_drained", 32'(iq.occupancy), 0);

        // Same-cycle bypass of a broadcast during dispatch.
        disp(3, 0, 4, 1, 21, 32'h2222);
        cdb(3);
        tick();
        idle();
        chk("byp_issue_valid", 32'(iq.issue_valid), 1);
        chk("byp_issue_dst", 32'(iq.issue_dst_tag), 21);
        tick();
        chk("byp_drained", 32'(iq.occupancy), 0);

        // Priority with stalled functional unit.
        iq.issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(1, 1, 2, 1, 10 + i, 32'(100 + i));
            tick();
        end
        idle();
        chk("pri_occ", 32'(iq.occupancy), 3);
        chk("pri_head", 32'(iq.issue_dst_tag), 10);
        tick();
        chk("pri_stall_hold", 32'(iq.issue_dst_tag), 10);
        chk("pri_stall_payload", iq.issue_payload, 100);
        iq.issue_ready = 1'b1;
        tick();
        chk("pri_second", 32'(iq.issue_dst_tag), 11);
        tick();
        chk("pri_third", 32'(iq.issue_dst_tag), 12);
        tick();
        chk("pri_empty", 32'(iq.issue_valid), 0);
        chk("pri_occ_zero", 32'(iq.occupancy), 0);

        // Fill to DEPTH with non-ready entries.
        iq.issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(40 + i, 0, 0, 1, 30 + i, 32'(200 + i));
            tick();
        end
        idle();
        chk("full_disp_ready", 32'(iq.disp_ready), 0);
        chk("full_occ", 32'(iq.occupancy), 8);
        chk("full_no_issue", 32'(iq.issue_valid), 0);
        disp(1, 1, 2, 1, 50, 32'h5050);
        tick();
        idle();
        chk("full_ninth_ignored", 32'(iq.occupancy), 8);
        chk("full_ninth_no_issue", 32'(iq.issue_valid), 0);
        cdb(44);
        tick();
        idle();
        chk("full_wake4_valid", 32'(iq.issue_valid), 1);
        chk("full_wake4_dst", 32'(iq.issue_dst_tag), 34);
        iq.issue_ready = 1'b1;
        chk("full_issue_cycle_ready", 32'(iq.disp_ready), 0);
        tick();
        iq.issue_ready = 1'b0;
        chk("full_ready_after_free", 32'(iq.disp_ready), 1);
        chk("full_occ_after_free", 32'(iq.occupancy), 7);
        disp(1, 1, 2, 1, 55, 32'h5555);
        tick();
        idle();
        chk("full_slot4_reuse_dst", 32'(iq.issue_dst_tag), 55);
        chk("full_slot4_reuse_pl", iq.issue_payload, 32'h5555);
        chk("full_refilled", 32'(iq.occupancy), 8);

        // Clear, then build five waiting entries and flush.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_occ", 32'(iq.occupancy), 0);
        for (int i = 0; i < 5; i++) begin
            disp(60, 0, 0, 1, i, 32'(300 + i));
            tick();
        end
        idle();
        chk("fl_occ5", 32'(iq.occupancy), 5);
        iq.flush = 1'b1;
        disp(1, 1, 2, 1, 7, 32'h7777);
        cdb(60);
        iq.issue_ready = 1'b1;
        tick();
        idle();
        chk("fl_occ", 32'(iq.occupancy), 0);
        chk("fl_issue_valid", 32'(iq.issue_valid), 0);
        chk("fl_disp_ready", 32'(iq.disp_ready), 1);
        tick();
        chk("fl_drop_occ", 32'(iq.occupancy), 0);
        chk("fl_drop_issue", 32'(iq.issue_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
